// File: rtl/ltpi_dc_pkg.sv
// Shared types and constants for the LTPI data-channel arbiter.
// Covers the sequencer states, response status codes and parameter defaults.
package ltpi_dc_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_RESP     = 2'd3
    } dc_arb_state_t;

    localparam logic [1:0] ST_OK         = 2'b00;
    localparam logic [1:0] ST_REMOTE_ERR = 2'b01;
    localparam logic [1:0] ST_TIMEOUT    = 2'b10;
    localparam logic [1:0] ST_LINK_DOWN  = 2'b11;

    localparam int DC_NUM_REQ     = 4;
    localparam int DC_DATA_W      = 32;
    localparam int DC_TAG_W       = 4;
    localparam int DC_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/ltpi_dc_arbiter_if.sv
// Requester-side and frame TX/RX-side buses of the data-channel arbiter.
// The master modport is the arbiter's view; slave is the surrounding logic.
interface ltpi_dc_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*DATA_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [1:0]                rsp_status;
    logic [DATA_W-1:0]         rsp_rdata;

    logic                      dc_req_valid;
    logic                      dc_req_ready;
    logic                      dc_req_write;
    logic [DATA_W-1:0]         dc_req_addr;
    logic [DATA_W-1:0]         dc_req_wdata;
    logic [TAG_W-1:0]          dc_req_tag;
    logic                      dc_rsp_valid;
    logic [TAG_W-1:0]          dc_rsp_tag;
    logic                      dc_rsp_err;
    logic [DATA_W-1:0]         dc_rsp_rdata;
    logic                      tag_mismatch;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  dc_req_ready, dc_rsp_valid, dc_rsp_tag, dc_rsp_err, dc_rsp_rdata,
        output req_ready, rsp_valid, rsp_status, rsp_rdata,
        output dc_req_valid, dc_req_write, dc_req_addr, dc_req_wdata, dc_req_tag,
        output tag_mismatch
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output dc_req_ready, dc_rsp_valid, dc_rsp_tag, dc_rsp_err, dc_rsp_rdata,
        input  req_ready, rsp_valid, rsp_status, rsp_rdata,
        input  dc_req_valid, dc_req_write, dc_req_addr, dc_req_wdata, dc_req_tag,
        input  tag_mismatch
    );
endinterface

// File: rtl/ltpi_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// searching upward with wrap.
module ltpi_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [PTR_W-1:0]   o_grant,
    output logic               o_any
);
    logic [PTR_W:0]     w_sum [NUM_REQ];
    logic [PTR_W-1:0]   w_idx [NUM_REQ];
    logic [NUM_REQ-1:0] w_hit;

    // Slot gi holds the requester index gi positions after the pointer.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign w_sum[gi] = {1'b0, i_ptr} + (PTR_W+1)'(gi);
            assign w_idx[gi] = (w_sum[gi] >= (PTR_W+1)'(NUM_REQ))
                             ? PTR_W'(w_sum[gi] - (PTR_W+1)'(NUM_REQ))
                             : w_sum[gi][PTR_W-1:0];
            assign w_hit[gi] = i_req[w_idx[gi]];
        end
    endgenerate

    always_comb begin
        o_grant = i_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_hit[i]) o_grant = w_idx[i];
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/ltpi_dc_arbiter.sv
// LTPI target data-channel arbiter: shares one tagged request/response path
// among NUM_REQ requesters, one transaction outstanding, with timeout and link-loss abort.
module ltpi_dc_arbiter
    import ltpi_dc_pkg::*;
#(
    parameter int NUM_REQ     = DC_NUM_REQ,
    parameter int DATA_W      = DC_DATA_W,
    parameter int TAG_W       = DC_TAG_W,
    parameter int TIMEOUT_CYC = DC_TIMEOUT_CYC
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_aligned,
    ltpi_dc_arbiter_if.master bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    dc_arb_state_t      r_state, w_state_next;
    logic [PTR_W-1:0]   r_rr_ptr, r_owner, w_grant;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [TAG_W-1:0]   r_tag;
    logic               r_write;
    logic [DATA_W-1:0]  r_addr, r_wdata;
    logic               w_any, w_grant_fire, w_tag_eq, w_mismatch;
    logic [1:0]         w_status;
    logic [DATA_W-1:0]  w_rdata;
    logic [NUM_REQ-1:0] w_grant_oh, w_owner_oh;
    logic [DATA_W-1:0]  w_req_addr  [NUM_REQ];
    logic [DATA_W-1:0]  w_req_wdata [NUM_REQ];

    logic [NUM_REQ-1:0] r_req_ready, r_rsp_valid;
    logic [1:0]         r_rsp_status;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic               r_dc_req_valid, r_tag_mismatch;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_req_addr[gi]  = bus.req_addr[gi*DATA_W +: DATA_W];
            assign w_req_wdata[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    ltpi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    assign w_tag_eq   = (bus.dc_rsp_tag == r_tag);
    assign w_grant_oh = NUM_REQ'(1) << w_grant;
    assign w_owner_oh = NUM_REQ'(1) << r_owner;
    // Any response not matching the outstanding tag while waiting is dropped.
    assign w_mismatch = bus.dc_rsp_valid && !((r_state == S_WAIT_RSP) && w_tag_eq);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_grant_fire = 1'b0;
        w_status     = ST_OK;
        w_rdata      = '0;
        unique case (r_state)
            S_IDLE: begin
                if (i_aligned && w_any) begin
                    w_grant_fire = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!i_aligned) begin
                    w_state_next = S_RESP;
                    w_status     = ST_LINK_DOWN;
                end else if (bus.dc_req_ready) begin
                    w_state_next = S_WAIT_RSP;
                    w_cnt_next   = '0;
                end
            end
            S_WAIT_RSP: begin
                // Priority: link loss, then a matching response, then timeout.
                if (!i_aligned) begin
                    w_state_next = S_RESP;
                    w_status     = ST_LINK_DOWN;
                end else if (bus.dc_rsp_valid && w_tag_eq) begin
                    w_state_next = S_RESP;
                    w_status     = bus.dc_rsp_err ? ST_REMOTE_ERR : ST_OK;
                    w_rdata      = bus.dc_rsp_err ? '0 : bus.dc_rsp_rdata;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_state_next = S_RESP;
                    w_status     = ST_TIMEOUT;
                end else begin
                    w_cnt_next   = r_cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_rr_ptr       <= '0;
            r_owner        <= '0;
            r_cnt          <= '0;
            r_tag          <= '0;
            r_write        <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_req_ready    <= '0;
            r_rsp_valid    <= '0;
            r_rsp_status   <= '0;
            r_rsp_rdata    <= '0;
            r_dc_req_valid <= 1'b0;
            r_tag_mismatch <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_req_ready    <= w_grant_fire ? w_grant_oh : '0;
            r_dc_req_valid <= (w_state_next == S_ISSUE);
            r_rsp_valid    <= (w_state_next == S_RESP) ? w_owner_oh : '0;
            r_rsp_status   <= (w_state_next == S_RESP) ? w_status : '0;
            r_rsp_rdata    <= (w_state_next == S_RESP) ? w_rdata : '0;
            r_tag_mismatch <= w_mismatch;
            if (w_grant_fire) begin
                r_owner  <= w_grant;
                r_write  <= bus.req_write[w_grant];
                r_addr   <= w_req_addr[w_grant];
                r_wdata  <= w_req_wdata[w_grant];
                r_rr_ptr <= (w_grant == PTR_W'(NUM_REQ - 1)) ? '0 : w_grant + PTR_W'(1);
            end
            if (r_state == S_RESP) r_tag <= r_tag + TAG_W'(1);
        end
    end

    assign bus.req_ready    = r_req_ready;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_status   = r_rsp_status;
    assign bus.rsp_rdata    = r_rsp_rdata;
    assign bus.dc_req_valid = r_dc_req_valid;
    assign bus.dc_req_write = r_write;
    assign bus.dc_req_addr  = r_addr;
    assign bus.dc_req_wdata = r_wdata;
    assign bus.dc_req_tag   = r_tag;
    assign bus.tag_mismatch = r_tag_mismatch;

endmodule
